// File: rtl/fifo_shadow_checker.sv
// Shadow-model monitor for a synchronous FIFO: tracks the expected FIFO state from the
// DUT's own requests, compares every DUT output each clock and accumulates error statistics.
module fifo_shadow_checker #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              check_en,
    input  logic              clr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              wr_ack,
    input  logic              overflow,
    input  logic              underflow,
    input  logic              full,
    input  logic              empty,
    input  logic              almostfull,
    input  logic              almostempty,
    output logic [CNT_W-1:0]  ok_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [7:0]        err_flags,
    output logic              first_err_vld,
    output logic [7:0]        first_err_code
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  lvl;
    logic [LVL_W-1:0]  lvl_nxt;
    logic              do_wr;
    logic              do_rd;
    logic              exp_wr_ack;
    logic              exp_ovf;
    logic              exp_udf;
    logic [DATA_W-1:0] exp_dout;
    logic              dout_chk;
    logic [7:0]        mm;
    logic              act;

    // Shadow FIFO reaction to this cycle's requests; a full FIFO only reads, an empty one only writes.
    always_comb begin
        do_wr   = wr_en && (lvl != LVL_FULL);
        do_rd   = rd_en && (lvl != '0);
        lvl_nxt = lvl;
        if (do_wr && !do_rd) begin
            lvl_nxt = lvl + LVL_ONE;
        end else if (do_rd && !do_wr) begin
            lvl_nxt = lvl - LVL_ONE;
        end
    end

    always_comb begin
        mm    = '0;
        mm[0] = dout_chk && (data_out != exp_dout);
        mm[1] = wr_ack ^ exp_wr_ack;
        mm[2] = overflow ^ exp_ovf;
        mm[3] = underflow ^ exp_udf;
        mm[4] = full ^ (lvl == LVL_FULL);
        mm[5] = empty ^ (lvl == '0);
        mm[6] = almostfull ^ (lvl == LVL_AF);
        mm[7] = almostempty ^ (lvl == LVL_ONE);
        act   = check_en && !clr;
    end

    // Storage needs no reset: a slot is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (rst_n && do_wr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lvl        <= '0;
            exp_wr_ack <= 1'b0;
            exp_ovf    <= 1'b0;
            exp_udf    <= 1'b0;
            exp_dout   <= '0;
            dout_chk   <= 1'b0;
        end else begin
            lvl        <= lvl_nxt;
            exp_wr_ack <= do_wr;
            exp_ovf    <= wr_en && (lvl == LVL_FULL);
            exp_udf    <= rd_en && (lvl == '0);
            dout_chk   <= do_rd;
            if (do_wr) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                exp_dout <= mem[rd_ptr];
                rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // first_err_vld qualifies first_err_code; once set, both hold until reset or clr.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            ok_count       <= '0;
            err_count      <= '0;
            err_flags      <= '0;
            first_err_vld  <= 1'b0;
            first_err_code <= '0;
        end else if (act) begin
            if (mm == '0) begin
                if (ok_count != CNT_MAX) begin
                    ok_count <= ok_count + 1'b1;
                end
            end else begin
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + 1'b1;
                end
                if (!first_err_vld) begin
                    first_err_vld  <= 1'b1;
                    first_err_code <= mm;
                end
            end
            err_flags <= err_flags | mm;
        end
    end

endmodule
